if_stage_prefetch: RTL

//  Parametrised instruction-fetch stage with a decoupled memory port and a prefetch queue.

---
 rtl/if_stage_prefetch_pkg.sv | 16 +
 rtl/if_stage_prefetch_if.sv | 24 ++
 rtl/if_stage_prefetch_fifo.sv | 53 +++++
 rtl/if_stage_prefetch.sv | 108 ++++++++++
 4 files changed

// File: rtl/if_stage_prefetch_pkg.sv
// Shared defaults and the fetch-entry record for the instruction-fetch stage.
// Widths here are the defaults; instances may override them through parameters.
package if_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam logic [ADDR_W-1:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_prefetch_if.sv
// Decoupled instruction-memory port: valid/ready request, in-order response.
// master = fetch stage, slave = memory.
interface if_stage_prefetch_if #(
  parameter int unsigned ADDR_W = if_pkg::ADDR_W,
  parameter int unsigned DATA_W = if_pkg::DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/if_stage_prefetch_fifo.sv
// Synchronous FIFO with flush, used both for in-flight request PCs and for the
// prefetch queue of {pc, instr} entries. Flush wins over push and pop.
module if_prefetch_fifo
  import if_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + (PW+1)'(1);
      else if (do_pop && !do_push) count <= count - (PW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; validity comes only from the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage: credit-limited sequential requests, in-order responses
// tagged with their PCs, prefetch queue to ID, flush and stale-response drop on branch.
module if_stage_prefetch #(
  parameter int unsigned       ADDR_W   = if_pkg::ADDR_W,
  parameter int unsigned       DATA_W   = if_pkg::DATA_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(if_pkg::PC_STEP),
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(if_pkg::RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          branch_address,
  if_stage_prefetch_if.master        imem,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_instruction
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  // Same layout as if_pkg::fetch_entry_t, sized by this instance's widths.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc, pc_head;
  logic [CW-1:0]     outstanding, outstanding_next;
  logic [CW-1:0]     drop, drop_next;
  logic [CW-1:0]     q_count, pc_count;
  logic              live;
  logic              accept, rsp_live, rsp_keep, pop;
  entry_t            q_head, q_push_data;

  // live holds requests off until the first edge after reset release.
  assign imem.req_valid = live && !branch_taken
                       && (({1'b0, q_count} + {1'b0, outstanding}) < CREDITS);
  assign imem.req_addr  = fetch_pc;

  assign accept   = imem.req_valid && imem.req_ready;
  assign rsp_live = imem.rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_live && (drop == '0) && !branch_taken;

  assign out_valid       = (q_count != '0);
  assign pop             = out_valid && !freeze && !branch_taken;
  assign out_pc          = out_valid ? q_head.pc : '0;
  assign out_instruction = out_valid ? q_head.instr : '0;
  assign q_push_data     = '{pc: pc_head, instr: imem.rsp_data};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    outstanding_next = outstanding;
    drop_next        = drop;
    if (accept)   outstanding_next = outstanding_next + CW'(1);
    if (rsp_live) outstanding_next = outstanding_next - CW'(1);
    if (branch_taken)               drop_next = outstanding - (rsp_live ? CW'(1) : '0);
    else if (rsp_live && drop != '0) drop_next = drop - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      live        <= 1'b0;
    end else begin
      live        <= 1'b1;
      outstanding <= outstanding_next;
      drop        <= drop_next;
      if (branch_taken) fetch_pc <= branch_address;
      else if (accept)  fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  if_prefetch_fifo #(.entry_t(logic [ADDR_W-1:0]), .DEPTH(DEPTH)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head      (pc_head),
    .count     (pc_count)
  );

  if_prefetch_fifo #(.entry_t(entry_t), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (rsp_keep),
    .push_data (q_push_data),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count)
  );

  // Every live request is either tagged in the PC FIFO or scheduled to be dropped.
  a_credit_balance: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, pc_count} + {1'b0, drop}) == {1'b0, outstanding});
  a_drop_bounded: assert property (@(posedge clk) disable iff (!rst) drop <= outstanding);
  a_no_stale_rsp: assert property (@(posedge clk) disable iff (!rst)
    imem.rsp_valid |-> (outstanding != '0))
    else $error("stale imem response ignored (nothing outstanding)");

endmodule
